enable_tick_gen: RTL and testbench

Upstream control stage for the 4-bit time counter. It debounces a raw run/stop pushbutton and toggles a RUNNING/STOPPED state on each press. While running, it emits a one-cycle `enable` pulse every `DIV` clocks; while stopped, it emits a single pulse per `step` request. `enable` connects directly to the counter's `enable` input, and both blocks share the same clock.

---
 rtl/enable_tick_gen.sv | 103 ++++++++++
 tb/tb_enable_tick_gen.sv | 102 ++++++++++
 2 files changed

// File: rtl/enable_tick_gen.sv
// Run/stop control for the time counter: it debounces a pushbutton, toggles RUNNING/STOPPED,
// and emits a one-cycle enable every DIV clocks while running, or once per step while stopped.
module enable_tick_gen #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic step,
  output logic enable,
  output logic running,
  output logic btn_press
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);

  localparam logic [PreW-1:0] PreMax = PreW'(DIV - 1);
  localparam logic [DbW-1:0]  DbMax  = DbW'(DB_CYCLES - 1);

  typedef enum logic {StStopped, StRunning} state_e;

  state_e          state_q, state_d;
  logic            s1_q, s2_q;
  logic            btn_db_q, btn_db_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic            step_d_q;
  logic            enable_q, enable_d;
  logic            btn_press_q;
  logic            press;

  // Debounce: a level change is accepted only after DB_CYCLES consecutive differing samples.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (s2_q != btn_db_q) begin
      if (db_cnt_q == DbMax) begin
        btn_db_d = s2_q;
        press    = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // A press always wins: it suppresses both the prescaler tick and a step pulse.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = '0;
    enable_d  = 1'b0;
    unique case (state_q)
      StStopped: begin
        if (press) begin
          state_d = StRunning;
        end else begin
          enable_d = step & ~step_d_q;
        end
      end
      StRunning: begin
        if (press) begin
          state_d = StStopped;
        end else if (pre_cnt_q == PreMax) begin
          enable_d = 1'b1;
        end else begin
          pre_cnt_d = pre_cnt_q + PreW'(1);
        end
      end
      default: state_d = StStopped;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StStopped;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      pre_cnt_q   <= '0;
      step_d_q    <= 1'b0;
      enable_q    <= 1'b0;
      btn_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= btn_raw;
      s2_q        <= s1_q;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      step_d_q    <= step;
      enable_q    <= enable_d;
      btn_press_q <= press;
    end
  end

  assign enable    = enable_q;
  assign running   = (state_q == StRunning);
  assign btn_press = btn_press_q;

endmodule

// File: tb/tb_enable_tick_gen.sv
// Directed bench for enable_tick_gen with DIV=5, DB_CYCLES=4; edge e below is the e-th rising
// edge of the main sequence, inputs set before it and outputs checked 1ns after it.
module tb_enable_tick_gen;

  logic clk = 1'b0;
  logic rst, btn_raw, step;
  logic enable, running, btn_press;

  int n_checks = 0;
  int n_fail   = 0;

  enable_tick_gen #(
    .DIV      (5),
    .DB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .step     (step),
    .enable   (enable),
    .running  (running),
    .btn_press(btn_press)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input int e, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", tag, e, obs, exp);
    end
  endtask

  // Hand-derived stimulus and expectations for the main sequence.
  function automatic logic btn_at(input int e);
    return (e <= 20) || (e >= 30 && e <= 40) || (e inside {51, 52, 53, 55, 56, 57}) ||
           (e >= 59 && e <= 64) || (e >= 70 && e <= 75);
  endfunction

  function automatic logic step_at(input int e);
    return (e == 23) || (e >= 47 && e <= 50);
  endfunction

  function automatic logic exp_running(input int e);
    return (e >= 5 && e < 35) || (e >= 64 && e < 67) || (e >= 75);
  endfunction

  function automatic logic exp_press(input int e);
    return e inside {5, 35, 64, 75};
  endfunction

  function automatic logic exp_enable(input int e);
    return e inside {10, 15, 20, 25, 30, 47, 80};
  endfunction

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b0;
    step    = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'($urandom_range(0, 1));
      step    = 1'($urandom_range(0, 1));
      tick();
      check_eq("rst_enable", i, enable, 1'b0);
      check_eq("rst_running", i, running, 1'b0);
      check_eq("rst_btn_press", i, btn_press, 1'b0);
    end

    rst     = 1'b0;
    btn_raw = 1'b0;
    step    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_enable", i, enable, 1'b0);
      check_eq("idle_running", i, running, 1'b0);
    end

    // Clean press, run ticks, step ignored while running, stop on tick edge, single step,
    // bounce rejection, reset mid-run with pre_cnt=2, restart.
    for (int e = 0; e <= 81; e++) begin
      btn_raw = btn_at(e);
      step    = step_at(e);
      rst     = (e == 67);
      tick();
      check_eq("enable", e, enable, exp_enable(e));
      check_eq("running", e, running, exp_running(e));
      check_eq("btn_press", e, btn_press, exp_press(e));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
